// File: rtl/sweep_pkg.sv
// Shared types and helpers for the subcircuit sweep sequencer.
package sweep_pkg;

    localparam int unsigned TGL_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } sweep_state_e;

    // Sweep position to applied vector: Gray code keeps one input toggling per step.
    function automatic logic [31:0] order_vec(input logic [31:0] idx, input logic gray);
        return gray ? (idx ^ (idx >> 1)) : idx;
    endfunction

    function automatic logic [TGL_W-1:0] popcount(input logic [31:0] x);
        logic [TGL_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            n = n + TGL_W'(x[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sweep_tgl_cnt.sv
// Saturating activity counter: adds inc_amt when inc_en is high, sticks at all-ones.
module sweep_tgl_cnt
    import sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc_en,
    input  logic [TGL_W-1:0] inc_amt,
    output logic [TGL_W-1:0] cnt
);

    logic [TGL_W:0] sum;

    always_comb begin
        sum = {1'b0, cnt} + {1'b0, inc_amt};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc_en) begin
            cnt <= sum[TGL_W] ? '1 : sum[TGL_W-1:0];
        end
    end

endmodule

// File: rtl/subckt_sweep_ctrl.sv
// Exhaustive vector sweep of a small combinational subcircuit against a golden truth table.
// Define SWEEP_TOGGLE_CNT_EN to build the input/output switching-activity counters.
module subckt_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int unsigned          N_IN         = 4,
    parameter int unsigned          SETTLE       = 1,
    parameter logic [(1<<N_IN)-1:0] GOLDEN       = 16'hFF40,
    parameter bit                   GRAY_ORDER   = 1'b1,
    parameter bit                   STOP_ON_FAIL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [N_IN-1:0]  vec_o,
    input  logic             dut_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [N_IN-1:0]  fail_vec_o,
    output logic [N_IN:0]    fail_cnt_o,
    output logic [TGL_W-1:0] in_tgl_o,
    output logic [TGL_W-1:0] out_tgl_o
);

    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    sweep_state_e state, state_nxt;

    logic [N_IN-1:0]  idx;
    logic [N_IN-1:0]  idx_inc;
    logic [N_IN-1:0]  vec_nxt;
    logic [CNT_W-1:0] settle_cnt;
    logic             mismatch;
    logic             last_vec;
    logic             settle_end;
    logic             accept;
    logic             advance;
    logic             sample;
    logic             do_abort;

    assign idx_inc    = idx + N_IN'(1);
    assign vec_nxt    = N_IN'(order_vec(32'(idx_inc), GRAY_ORDER));
    assign mismatch   = (dut_out_i != GOLDEN[vec_o]);
    assign last_vec   = (idx == '1);
    assign settle_end = (settle_cnt == CNT_W'(SETTLE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        advance   = 1'b0;
        sample    = 1'b0;
        do_abort  = 1'b0;
        // Abort wins over everything, including the final sample of a sweep.
        if (state != ST_IDLE && abort_i) begin
            state_nxt = ST_IDLE;
            do_abort  = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state_nxt = ST_SETTLE;
                        accept    = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_end) begin
                        state_nxt = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    sample = 1'b1;
                    if (last_vec || (STOP_ON_FAIL && mismatch)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_SETTLE;
                        advance   = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign done_o = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            vec_o      <= '0;
            settle_cnt <= '0;
            pass_o     <= 1'b0;
            fail_vec_o <= '0;
            fail_cnt_o <= '0;
        end else if (do_abort) begin
            idx    <= '0;
            vec_o  <= '0;
            pass_o <= 1'b0;
        end else if (accept) begin
            idx        <= '0;
            vec_o      <= N_IN'(order_vec(32'd0, GRAY_ORDER));
            settle_cnt <= '0;
            pass_o     <= 1'b1;
            fail_vec_o <= '0;
            fail_cnt_o <= '0;
        end else begin
            if (state == ST_SETTLE) begin
                settle_cnt <= settle_cnt + CNT_W'(1);
            end
            if (sample && mismatch) begin
                fail_cnt_o <= fail_cnt_o + (N_IN + 1)'(1);
                pass_o     <= 1'b0;
                if (fail_cnt_o == '0) begin
                    fail_vec_o <= vec_o;
                end
            end
            if (advance) begin
                idx        <= idx_inc;
                vec_o      <= vec_nxt;
                settle_cnt <= '0;
            end
        end
    end

`ifdef SWEEP_TOGGLE_CNT_EN
    logic prev_smp;
    logic have_prev;
    logic out_chg;

    // First sample of a sweep has no predecessor and never counts as a change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_smp  <= 1'b0;
            have_prev <= 1'b0;
        end else if (accept) begin
            prev_smp  <= 1'b0;
            have_prev <= 1'b0;
        end else if (sample && !do_abort) begin
            prev_smp  <= dut_out_i;
            have_prev <= 1'b1;
        end
    end

    assign out_chg = sample && have_prev && (dut_out_i != prev_smp);

    sweep_tgl_cnt u_in_tgl (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .inc_en  (advance),
        .inc_amt (popcount(32'(vec_o ^ vec_nxt))),
        .cnt     (in_tgl_o)
    );

    sweep_tgl_cnt u_out_tgl (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .inc_en  (out_chg),
        .inc_amt (TGL_W'(1)),
        .cnt     (out_tgl_o)
    );
`else
    assign in_tgl_o  = '0;
    assign out_tgl_o = '0;
`endif

endmodule

// File: tb/tb_subckt_sweep_ctrl.sv
// Randomized self-checking bench for subckt_sweep_ctrl: a default instance and a
// binary-order / SETTLE=3 / stop-on-fail instance, both checked against a sweep model.
module tb_subckt_sweep_ctrl;

    localparam int unsigned NV   = 16;
    localparam logic [15:0] GOLD = 16'hFF40;
`ifdef SWEEP_TOGGLE_CNT_EN
    localparam bit TGL_ON = 1'b1;
`else
    localparam bit TGL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic sel = 1'b0;

    logic       start0, start1, abort0, abort1;
    logic [3:0] vec0, vec1, fvec0, fvec1;
    logic       out0, out1, busy0, busy1, done0, done1, pass0, pass1;
    logic [4:0] fcnt0, fcnt1;
    logic [7:0] itgl0, itgl1, otgl0, otgl1;

    logic [3:0] m_vec, m_fvec;
    logic       m_busy, m_done, m_pass;
    logic [4:0] m_fcnt;
    logic [7:0] m_itgl, m_otgl;

    logic [15:0] act_tt = GOLD;
    logic [15:0] gold_tt = GOLD;
    logic [1:0]  delay = 2'd0;
    logic [3:0]  dl0 [1:3];
    logic [3:0]  dl1 [1:3];

    int unsigned n_run = 0;
    int unsigned n_fail = 0;
    int unsigned exp_pass, exp_fcnt, exp_fvec, exp_itgl, exp_otgl, exp_nv;

    always #5 clk = ~clk;

    assign start0 = start & ~sel;
    assign start1 = start & sel;
    assign abort0 = abort & ~sel;
    assign abort1 = abort & sel;

    subckt_sweep_ctrl u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start0), .abort_i(abort0), .vec_o(vec0),
        .dut_out_i(out0), .busy_o(busy0), .done_o(done0), .pass_o(pass0),
        .fail_vec_o(fvec0), .fail_cnt_o(fcnt0), .in_tgl_o(itgl0), .out_tgl_o(otgl0)
    );

    subckt_sweep_ctrl #(
        .N_IN(4), .SETTLE(3), .GOLDEN(16'hFF40), .GRAY_ORDER(1'b0), .STOP_ON_FAIL(1'b1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .abort_i(abort1), .vec_o(vec1),
        .dut_out_i(out1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
        .fail_vec_o(fvec1), .fail_cnt_o(fcnt1), .in_tgl_o(itgl1), .out_tgl_o(otgl1)
    );

    // Subcircuit stand-in: truth table act_tt seen through a 0..3 cycle input delay.
    always @(posedge clk) begin
        dl0[1] <= vec0; dl0[2] <= dl0[1]; dl0[3] <= dl0[2];
        dl1[1] <= vec1; dl1[2] <= dl1[1]; dl1[3] <= dl1[2];
    end

    always_comb begin
        out0 = act_tt[(delay == 2'd0) ? vec0 : dl0[delay]];
        out1 = act_tt[(delay == 2'd0) ? vec1 : dl1[delay]];
    end

    assign m_vec  = sel ? vec1  : vec0;
    assign m_busy = sel ? busy1 : busy0;
    assign m_done = sel ? done1 : done0;
    assign m_pass = sel ? pass1 : pass0;
    assign m_fvec = sel ? fvec1 : fvec0;
    assign m_fcnt = sel ? fcnt1 : fcnt0;
    assign m_itgl = sel ? itgl1 : itgl0;
    assign m_otgl = sel ? otgl1 : otgl0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
        end
    endtask

    function automatic int unsigned ord(input bit gray, input int unsigned k);
        return gray ? (k ^ (k >> 1)) : k;
    endfunction

    // Walk the sweep order over at most 'limit' vectors and accumulate the expected results.
    task automatic model(input bit gray, input bit stop, input int unsigned limit);
        int unsigned v, pv;
        bit o, po;
        exp_pass = 1; exp_fcnt = 0; exp_fvec = 0; exp_itgl = 0; exp_otgl = 0; exp_nv = 0;
        pv = 0; po = 1'b0;
        for (int unsigned k = 0; k < NV && k < limit; k++) begin
            v = ord(gray, k);
            o = act_tt[v];
            if (k > 0) begin
                exp_itgl = exp_itgl + $countones(v ^ pv);
                if (o != po) exp_otgl = exp_otgl + 1;
                if (exp_itgl > 255) exp_itgl = 255;
                if (exp_otgl > 255) exp_otgl = 255;
            end
            pv = v; po = o; exp_nv = k + 1;
            if (o != gold_tt[v]) begin
                if (exp_fcnt == 0) exp_fvec = v;
                exp_fcnt = exp_fcnt + 1;
                exp_pass = 0;
                if (stop) break;
            end
        end
    endtask

    task automatic check_results(input string pfx, input bit aborted);
        check({pfx, "_pass"}, 32'(m_pass), aborted ? 0 : exp_pass);
        check({pfx, "_fcnt"}, 32'(m_fcnt), exp_fcnt);
        check({pfx, "_fvec"}, 32'(m_fvec), exp_fvec);
        check({pfx, "_itgl"}, 32'(m_itgl), TGL_ON ? exp_itgl : 0);
        check({pfx, "_otgl"}, 32'(m_otgl), TGL_ON ? exp_otgl : 0);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_vec"},  32'(m_vec), 0);
        check({pfx, "_busy"}, 32'(m_busy), 0);
        check({pfx, "_done"}, 32'(m_done), 0);
        check({pfx, "_pass"}, 32'(m_pass), 0);
        check({pfx, "_fvec"}, 32'(m_fvec), 0);
        check({pfx, "_fcnt"}, 32'(m_fcnt), 0);
        check({pfx, "_itgl"}, 32'(m_itgl), 0);
        check({pfx, "_otgl"}, 32'(m_otgl), 0);
    endtask

    // Edge 0 is the edge that accepts start (cycle 1); vector k is sampled at edge (k+1)*(S+1),
    // so with no stop/abort done_o shows after edge 16*(S+1), i.e. cycle 16*(S+1)+1.
    task automatic run_sweep(input int unsigned abort_vec, input bit hold);
        bit cg, cs, aborting;
        int unsigned s, a, end_e;
        cg = !sel; cs = sel; s = sel ? 3 : 1;
        model(cg, cs, NV);
        aborting = (abort_vec != 0) && (exp_nv > abort_vec);
        a = 0;
        if (aborting) begin
            a = abort_vec * (s + 1) + 1 + $urandom_range(s, 0);
            model(cg, cs, abort_vec);
            end_e = a;
        end else begin
            end_e = exp_nv * (s + 1);
        end
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int unsigned j = 0; j < end_e; j++) begin
            check("run_busy", 32'(m_busy), 1);
            check("run_done", 32'(m_done), 0);
            check("run_vec", 32'(m_vec), ord(cg, j / (s + 1)));
            if (aborting && j == a - 1) abort = 1'b1;
            @(posedge clk); #1;
        end
        abort = 1'b0;
        if (aborting) begin
            check("abt_busy", 32'(m_busy), 0);
            check("abt_done", 32'(m_done), 0);
            check("abt_vec", 32'(m_vec), 0);
            check_results("abt", 1'b1);
        end else begin
            check("end_done", 32'(m_done), 1);
            check("end_busy", 32'(m_busy), 0);
            check_results("end", 1'b0);
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("post_done", 32'(m_done), 0);
        check("post_busy", 32'(m_busy), 0);
        check_results("hold", aborting);
    endtask

    initial begin
        #1;
        sel = 1'b0; check_all_zero("rst0");
        sel = 1'b1; check_all_zero("rst1");
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // Ideal subcircuit, default Gray-order instance.
        sel = 1'b0; act_tt = GOLD; delay = 2'd0;
        run_sweep(0, 1'b0);
        check("plan_g_pass", 32'(m_pass), 1);
        check("plan_g_itgl", 32'(m_itgl), TGL_ON ? 15 : 0);
        check("plan_g_otgl", 32'(m_otgl), TGL_ON ? 3 : 0);

        // Stuck-at-0 subcircuit.
        act_tt = '0;
        run_sweep(0, 1'b0);
        check("plan_s0_fcnt", 32'(m_fcnt), 9);
        check("plan_s0_fvec", 32'(m_fvec), 6);

        // Binary order, SETTLE=3, output lagging by two cycles.
        sel = 1'b1; act_tt = GOLD; delay = 2'd2;
        run_sweep(0, 1'b0);
        check("plan_b_pass", 32'(m_pass), 1);
        check("plan_b_itgl", 32'(m_itgl), TGL_ON ? 26 : 0);
        check("plan_b_otgl", 32'(m_otgl), TGL_ON ? 3 : 0);

        // Stop on first failure.
        act_tt = '0; delay = 2'd0;
        run_sweep(0, 1'b0);
        check("plan_stop_fcnt", 32'(m_fcnt), 1);

        // Abort during vector 7, then a full sweep with start held high throughout.
        sel = 1'b0; act_tt = GOLD ^ 16'h0005; delay = 2'd1;
        run_sweep(7, 1'b0);
        run_sweep(0, 1'b1);

        // Asynchronous reset mid-sweep, then a clean sweep.
        for (int unsigned r = 0; r < 2; r++) begin
            sel = r[0];
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat ($urandom_range(20, 3)) @(posedge clk);
            #3 rst_n = 1'b0;
            #1 check_all_zero("arst");
            @(posedge clk); #2;
            check_all_zero("arst_hold");
            rst_n = 1'b1;
            @(posedge clk); #1;
            act_tt = GOLD;
            run_sweep(0, 1'b0);
        end

        for (int unsigned it = 0; it < 24; it++) begin
            sel = $urandom_range(1, 0) == 1;
            case ($urandom_range(3, 0))
                0: act_tt = GOLD;
                1: act_tt = '0;
                2: act_tt = GOLD ^ 16'($urandom & $urandom & $urandom);
                default: act_tt = 16'($urandom);
            endcase
            delay = 2'($urandom_range(sel ? 3 : 1, 0));
            run_sweep(($urandom_range(3, 0) == 0) ? $urandom_range(14, 1) : 0,
                      $urandom_range(1, 0) == 1);
            repeat ($urandom_range(2, 0)) @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
